// File: rtl/mult_arbiter_if.sv
// Request/result bus of the shared multiplier arbiter.
// Handshake: requester i's operands transfer on a rising edge where
// req_valid[i] & req_grant[i]; results have no backpressure and res_valid
// is a one-cycle pulse qualifying res_data/res_id.
interface mult_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
);
  logic [N_REQ-1:0]   req_valid;
  logic [27*N_REQ-1:0] req_a;
  logic [27*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]   req_grant;
  logic               res_valid;
  logic [26:0]        res_data;
  logic [IDW-1:0]     res_id;

  modport master (
    output req_valid, req_a, req_b,
    input  req_grant, res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_grant, res_valid, res_data, res_id
  );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter in front of one shared 27x27 signed 4.23 multiplier.
// Two-stage pipeline: S1 holds granted operands + ID, S2 holds product + ID.
module mult_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           en,
  mult_arbiter_if.slave  bus,
  output logic [15:0]    op_count,
  output logic           busy
);

  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   idx;
  logic [IDW-1:0]   grant_idx;
  logic             grant_any;
  logic [N_REQ-1:0] grant_vec;

  logic             s1_valid;
  logic [26:0]      s1_a;
  logic [26:0]      s1_b;
  logic [IDW-1:0]   s1_id;

  logic             s2_valid;
  logic [26:0]      s2_data;
  logic [IDW-1:0]   s2_id;

  logic signed [53:0] product;
  logic               unused_bits;

  // First valid requester searched upward from rr_ptr; IDW-bit wrap gives mod N_REQ.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = rr_ptr + IDW'(k);
      if (!grant_any && en && reset_n && bus.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
    grant_vec = grant_any ? (N_REQ'(1) << grant_idx) : '0;
  end

  assign bus.req_grant = grant_vec;

  assign product     = $signed(s1_a) * $signed(s1_b);
  assign unused_bits = ^{product[52:49], product[22:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr   <= '0;
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_id    <= '0;
      op_count <= '0;
    end else begin
      s1_valid <= grant_any;
      if (grant_any) begin
        rr_ptr <= grant_idx + IDW'(1);
        s1_a   <= bus.req_a[27*grant_idx +: 27];
        s1_b   <= bus.req_b[27*grant_idx +: 27];
        s1_id  <= grant_idx;
      end
      s2_valid <= s1_valid;
      // Counting on the edge that raises res_valid lets op_count already
      // include the product being presented in that cycle.
      if (s1_valid) begin
        s2_data  <= {product[53], product[48:46], product[45:23]};
        s2_id    <= s1_id;
        op_count <= op_count + 16'd1;
      end
    end
  end

  assign bus.res_valid = s2_valid;
  assign bus.res_data  = s2_data;
  assign bus.res_id    = s2_id;
  assign busy          = s1_valid | s2_valid;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: one task per scenario, inline checks,
// expected-result queue for the streaming scenarios.
module tb_mult_arbiter;

  localparam int N_REQ = 4;
  localparam int IDW   = 2;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic [15:0] op_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [28:0] exp_q[$];

  mult_arbiter_if #(.N_REQ(N_REQ), .IDW(IDW)) bus ();

  mult_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .bus      (bus),
    .op_count (op_count),
    .busy     (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic set_op(input int i, input logic [26:0] a, input logic [26:0] b);
    bus.req_a[27*i +: 27] = a;
    bus.req_b[27*i +: 27] = b;
  endtask

  task automatic set_all_ops();
    for (int i = 0; i < N_REQ; i++) set_op(i, 27'(i + 1) << 23, 27'h0800000);
  endtask

  task automatic pop_check(input string name);
    logic [28:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got id=%0d data=%h with empty expected queue", name, bus.res_id, bus.res_data);
    end else begin
      e = exp_q.pop_front();
      if (bus.res_valid !== 1'b1 || {bus.res_id, bus.res_data} !== e) begin
        errors++;
        $display("FAIL %s: got v=%b id=%0d data=%h expected id=%0d data=%h",
                 name, bus.res_valid, bus.res_id, bus.res_data, e[28:27], e[26:0]);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0; en = 1'b1; bus.req_valid = '1;
    #1;
    checks++; if (bus.req_grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", bus.req_grant); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid); end
    checks++; if (op_count !== 16'h0) begin errors++; $display("FAIL reset_op_count: got %h expected 0000", op_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({bus.res_id, bus.res_data} !== 29'h0) begin errors++; $display("FAIL reset_res: got id=%0d data=%h expected 0", bus.res_id, bus.res_data); end
    @(negedge clk);
    reset_n = 1'b1; bus.req_valid = '0;
  endtask

  task automatic test_single_op();
    @(negedge clk);
    set_op(2, 27'h0C00000, 27'h1000000);
    bus.req_valid = 4'b0100;
    #1;
    checks++; if (bus.req_grant !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected 0100", bus.req_grant); end
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    checks++; if (bus.res_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_stage1: got v=%b busy=%b expected v=0 busy=1", bus.res_valid, busy); end
    @(negedge clk);
    checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 27'h1800000 || bus.res_id !== 2'd2 || op_count !== 16'd1) begin
      errors++; $display("FAIL single_result: got v=%b data=%h id=%0d cnt=%0d expected v=1 data=1800000 id=2 cnt=1", bus.res_valid, bus.res_data, bus.res_id, op_count);
    end
    @(negedge clk);
    checks++; if (bus.res_valid !== 1'b0 || bus.res_data !== 27'h1800000 || bus.res_id !== 2'd2 || busy !== 1'b0) begin
      errors++; $display("FAIL single_hold: got v=%b data=%h id=%0d busy=%b expected v=0 data=1800000 id=2 busy=0", bus.res_valid, bus.res_data, bus.res_id, busy);
    end
  endtask

  task automatic test_signed();
    @(negedge clk);
    set_op(0, 27'h7800000, 27'h0400000);
    bus.req_valid = 4'b0001;
    #1;
    checks++; if (bus.req_grant !== 4'b0001) begin errors++; $display("FAIL signed_grant: got %b expected 0001", bus.req_grant); end
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 27'h7C00000 || bus.res_id !== 2'd0 || op_count !== 16'd2) begin
      errors++; $display("FAIL signed_result: got v=%b data=%h id=%0d cnt=%0d expected v=1 data=7c00000 id=0 cnt=2", bus.res_valid, bus.res_data, bus.res_id, op_count);
    end
  endtask

  task automatic test_back_to_back_overflow();
    @(negedge clk);
    set_op(1, 27'h3FFFFFF, 27'h3FFFFFF);
    bus.req_valid = 4'b0010;
    #1;
    checks++; if (bus.req_grant !== 4'b0010) begin errors++; $display("FAIL ovf_grant1: got %b expected 0010", bus.req_grant); end
    @(negedge clk);
    set_op(3, 27'h4000000, 27'h4000000);
    bus.req_valid = 4'b1000;
    #1;
    checks++; if (bus.req_grant !== 4'b1000) begin errors++; $display("FAIL ovf_grant3: got %b expected 1000", bus.req_grant); end
    @(negedge clk);
    bus.req_valid = '0;
    checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 27'h3FFFFF0 || bus.res_id !== 2'd1 || op_count !== 16'd3) begin
      errors++; $display("FAIL ovf_pos: got v=%b data=%h id=%0d cnt=%0d expected v=1 data=3fffff0 id=1 cnt=3", bus.res_valid, bus.res_data, bus.res_id, op_count);
    end
    @(negedge clk);
    checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 27'h0000000 || bus.res_id !== 2'd3 || op_count !== 16'd4) begin
      errors++; $display("FAIL ovf_neg: got v=%b data=%h id=%0d cnt=%0d expected v=1 data=0000000 id=3 cnt=4", bus.res_valid, bus.res_data, bus.res_id, op_count);
    end
    @(negedge clk);
    checks++; if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ovf_drain: got v=%b busy=%b expected 0 0", bus.res_valid, busy); end
  endtask

  task automatic test_fairness();
    logic [3:0] eg;
    @(negedge clk);
    reset_n = 1'b0; en = 1'b1; set_all_ops(); bus.req_valid = '1;
    exp_q.delete();
    #1;
    checks++; if (bus.req_grant !== 4'b0000) begin errors++; $display("FAIL fair_grant_in_reset: got %b expected 0000", bus.req_grant); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      eg = 4'b0001 << (k % 4);
      checks++; if (bus.req_grant !== eg) begin errors++; $display("FAIL fair_grant_%0d: got %b expected %b", k, bus.req_grant, eg); end
      if (k >= 1) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fair_busy_%0d: got %b expected 1", k, busy); end
      end
      if (k >= 2) pop_check("fair_result");
      exp_q.push_back({2'(k % 4), 27'((k % 4) + 1) << 23});
    end
    @(negedge clk);
    bus.req_valid = '0;
    pop_check("fair_drain_a");
    @(negedge clk);
    pop_check("fair_drain_b");
    checks++; if (op_count !== 16'd12) begin errors++; $display("FAIL fair_count: got %0d expected 12", op_count); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL fair_idle: got busy=%b v=%b expected 0 0", busy, bus.res_valid); end
  endtask

  task automatic test_en_gating();
    logic [3:0] g_seq [6] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
    logic       en_seq[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_q.delete();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.req_valid = '1;
      en = en_seq[k];
      #1;
      checks++; if (bus.req_grant !== g_seq[k]) begin errors++; $display("FAIL en_grant_%0d: got %b expected %b", k, bus.req_grant, g_seq[k]); end
      if (k == 2 || k == 3) pop_check("en_drain");
      if (k == 4) begin
        checks++; if (busy !== 1'b0 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL en_drained: got busy=%b v=%b expected 0 0", busy, bus.res_valid); end
      end
      if (g_seq[k] == 4'b0001) exp_q.push_back({2'd0, 27'h0800000});
      if (g_seq[k] == 4'b0010) exp_q.push_back({2'd1, 27'h1000000});
      if (g_seq[k] == 4'b0100) exp_q.push_back({2'd2, 27'h1800000});
    end
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    pop_check("en_resume");
    checks++; if (op_count !== 16'd15) begin errors++; $display("FAIL en_count: got %0d expected 15", op_count); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    bus.req_valid = 4'b0100;
    #1;
    checks++; if (bus.req_grant !== 4'b0100) begin errors++; $display("FAIL mid_grant: got %b expected 0100", bus.req_grant); end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || op_count !== 16'd0) begin errors++; $display("FAIL mid_async_clear: got busy=%b cnt=%0d expected 0 0", busy, op_count); end
    #1 reset_n = 1'b1;
    bus.req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b0 || op_count !== 16'd0) begin errors++; $display("FAIL mid_no_result_%0d: got v=%b cnt=%0d expected 0 0", k, bus.res_valid, op_count); end
    end
    bus.req_valid = 4'b1010;
    #1;
    checks++; if (bus.req_grant !== 4'b0010) begin errors++; $display("FAIL mid_first_grant: got %b expected 0010", bus.req_grant); end
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    checks++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd1 || op_count !== 16'd1) begin errors++; $display("FAIL mid_after: got v=%b id=%0d cnt=%0d expected 1 1 1", bus.res_valid, bus.res_id, op_count); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    reset_n = 1'b0;
    set_all_ops();
    #1 reset_n = 1'b1;
    en = 1'b1;
    bus.req_valid = '1;
    repeat (65536) @(posedge clk);
    @(negedge clk);
    bus.req_valid = '0;
    checks++; if (op_count !== 16'hFFFF || bus.res_valid !== 1'b1) begin errors++; $display("FAIL wrap_ffff: got cnt=%h v=%b expected ffff 1", op_count, bus.res_valid); end
    @(negedge clk);
    checks++; if (op_count !== 16'h0000 || bus.res_valid !== 1'b1) begin errors++; $display("FAIL wrap_zero: got cnt=%h v=%b expected 0000 1", op_count, bus.res_valid); end
    @(negedge clk);
    checks++; if (op_count !== 16'h0000 || busy !== 1'b0 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL wrap_idle: got cnt=%h busy=%b v=%b expected 0000 0 0", op_count, busy, bus.res_valid); end
  endtask

  initial begin
    reset_n = 1'b0;
    en = 1'b0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    test_reset();
    test_single_op();
    test_signed();
    test_back_to_back_overflow();
    test_fairness();
    test_en_gating();
    test_reset_midflight();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
